rgb_pwm_drv: RTL and testbench

Parametrised multi-channel RGB LED driver, successor to the single-LED on/off `rgb_drv`. Drives `CHANNELS` RGB LEDs with independent per-colour PWM duty, loaded through a valid/ready write port. Global animation modes: off, static, breathe and hue-cycle. Sits between the pedal control logic (effect/status colours) and the board LED pins.

---
 rtl/rgb_pwm_drv.sv | 241 ++++++++++++++++++++++++
 tb/tb_rgb_pwm_drv.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_drv.sv
// rgb_pwm_drv: multi-channel RGB LED PWM driver.
// A valid/ready write port loads per-channel shadow colours. Shadows are
// copied to the active duty registers only on the PWM period boundary,
// so a period never shows a mix of old and new duty. Global modes are
// OFF, STATIC, BREATHE and hue CYCLE.
// Build option: define RGB_PWM_DRV_BREATHE_EN to build the breathe level
// counter and scaling multipliers. Without it, mode 2 behaves as STATIC.
module rgb_pwm_drv #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned PRESCALE = 64
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic [1:0]                                         mode,
  input  logic                                               wr_valid,
  output logic                                               wr_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
  input  logic [3*PWM_W-1:0]                                 wr_rgb,
  output logic [CHANNELS-1:0]                                red,
  output logic [CHANNELS-1:0]                                grn,
  output logic [CHANNELS-1:0]                                blu
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned PH_W   = PWM_W + 2;
  localparam int unsigned PROD_W = 2 * PWM_W;

  localparam logic [PWM_W-1:0] DUTY_MAX = '1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(3 * (2 ** PWM_W) - 1);

  // One colour triple, ordered to match the write payload {red, grn, blu}.
  typedef struct packed {
    logic [PWM_W-1:0] red;
    logic [PWM_W-1:0] grn;
    logic [PWM_W-1:0] blu;
  } rgb_t;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STATIC  = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_CYCLE   = 2'd3
  } mode_e;

  logic [PRE_W-1:0] pre_q;
  logic [PWM_W-1:0] cnt_q;
  logic             tick_c;
  logic             bound_c;
  logic             wr_acc_c;
  mode_e            mode_q;
  logic [PH_W-1:0]  p_q;
  logic [1:0]       seg_c;
  logic [PWM_W-1:0] frac_c;
  rgb_t             hue_c;
  rgb_t             shadow_q [CHANNELS];
  rgb_t             active_q [CHANNELS];
  rgb_t             duty_c   [CHANNELS];

  assign tick_c   = (pre_q == PRE_LAST);
  assign bound_c  = tick_c && (cnt_q == DUTY_MAX);
  assign wr_acc_c = wr_valid && wr_ready;

  // Prescaler and PWM step counter; cnt wraps naturally at 2^PWM_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else if (tick_c) begin
      pre_q <= '0;
      cnt_q <= cnt_q + PWM_W'(1);
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // Write port is held off only while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready <= 1'b0;
    end else begin
      wr_ready <= 1'b1;
    end
  end

  // Shadow colours take writes any time; active colours load on the boundary.
  // A write coinciding with the boundary lands in the shadow only.
  // Writes to channels beyond CHANNELS match no register and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bound_c) begin
          active_q[i] <= shadow_q[i];
        end
        if (wr_acc_c && (wr_ch == CH_W'(i))) begin
          shadow_q[i] <= rgb_t'(wr_rgb);
        end
      end
    end
  end

  // Animation mode is latched once per period so duty never changes mid-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
    end else if (bound_c) begin
      mode_q <= mode_e'(mode);
    end
  end

  // Hue phase advances only across periods that were spent in CYCLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (bound_c && (mode_q == MODE_CYCLE)) begin
      p_q <= (p_q == PH_LAST) ? '0 : p_q + PH_W'(1);
    end
  end

  assign seg_c  = p_q[PH_W-1:PWM_W];
  assign frac_c = p_q[PWM_W-1:0];

  // Hue wheel: each segment cross-fades one colour down and the next up.
  always_comb begin
    hue_c = '0;
    case (seg_c)
      2'd0: begin
        hue_c.red = DUTY_MAX - frac_c;
        hue_c.grn = frac_c;
      end
      2'd1: begin
        hue_c.grn = DUTY_MAX - frac_c;
        hue_c.blu = frac_c;
      end
      2'd2: begin
        hue_c.blu = DUTY_MAX - frac_c;
        hue_c.red = frac_c;
      end
      default: ;
    endcase
  end

`ifdef RGB_PWM_DRV_BREATHE_EN
  typedef enum logic {
    BR_UP   = 1'b0,
    BR_DOWN = 1'b1
  } br_e;

  br_e              br_q;
  br_e              br_d;
  logic [PWM_W-1:0] b_q;
  logic [PWM_W-1:0] b_d;

  // Scale a colour by the breathe level, keeping the top half of the product.
  function automatic logic [PWM_W-1:0] scale(input logic [PWM_W-1:0] c,
                                             input logic [PWM_W-1:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'(lvl);
    return prod[PROD_W-1:PWM_W];
  endfunction

  // Breathe direction and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q <= BR_UP;
      b_q  <= '0;
    end else begin
      br_q <= br_d;
      b_q  <= b_d;
    end
  end

  // Level ramps one step per breathe period; at either end it holds one
  // period while the direction flips.
  always_comb begin
    br_d = br_q;
    b_d  = b_q;
    if (bound_c && (mode_q == MODE_BREATHE)) begin
      case (br_q)
        BR_UP: begin
          if (b_q == DUTY_MAX) begin
            br_d = BR_DOWN;
          end else begin
            b_d = b_q + PWM_W'(1);
          end
        end
        BR_DOWN: begin
          if (b_q == '0) begin
            br_d = BR_UP;
          end else begin
            b_d = b_q - PWM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
`endif

  // Effective duty per channel for the latched mode.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_c[i] = active_q[i];
      case (mode_q)
        MODE_OFF:   duty_c[i] = '0;
        MODE_CYCLE: duty_c[i] = hue_c;
`ifdef RGB_PWM_DRV_BREATHE_EN
        MODE_BREATHE: begin
          duty_c[i].red = scale(active_q[i].red, b_q);
          duty_c[i].grn = scale(active_q[i].grn, b_q);
          duty_c[i].blu = scale(active_q[i].blu, b_q);
        end
`endif
        default: ;
      endcase
    end
  end

  // Registered PWM compare; a live OFF request blanks the pins on the next clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red <= '0;
      grn <= '0;
      blu <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        red[i] <= (mode != 2'd0) && (cnt_q < duty_c[i].red);
        grn[i] <= (mode != 2'd0) && (cnt_q < duty_c[i].grn);
        blu[i] <= (mode != 2'd0) && (cnt_q < duty_c[i].blu);
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_drv.sv
// Directed bench for rgb_pwm_drv with CHANNELS=3, PWM_W=4, PRESCALE=1.
// One PWM period is 16 clks; duty is checked by counting high clks per period.
module tb_rgb_pwm_drv;

  localparam int unsigned CHANNELS = 3;
  localparam int unsigned PWM_W    = 4;
  localparam int unsigned PRESCALE = 1;
  localparam int          PERIOD   = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [1:0]          mode;
  logic                wr_valid;
  logic                wr_ready;
  logic [1:0]          wr_ch;
  logic [3*PWM_W-1:0]  wr_rgb;
  logic [CHANNELS-1:0] red;
  logic [CHANNELS-1:0] grn;
  logic [CHANNELS-1:0] blu;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hr[CHANNELS];
  int hg[CHANNELS];
  int hb[CHANNELS];

  always #5 clk = ~clk;

  rgb_pwm_drv #(
    .CHANNELS(CHANNELS),
    .PWM_W(PWM_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_ch(wr_ch),
    .wr_rgb(wr_rgb),
    .red(red),
    .grn(grn),
    .blu(blu)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clk, sample 1 time unit later and accumulate high counts.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < CHANNELS; i++) begin
      hr[i] += int'(red[i]);
      hg[i] += int'(grn[i]);
      hb[i] += int'(blu[i]);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < CHANNELS; i++) begin
      hr[i] = 0;
      hg[i] = 0;
      hb[i] = 0;
    end
  endtask

  task automatic measure();
    clear();
    repeat (PERIOD) step();
  endtask

  task automatic goto_boundary();
    while (cyc % PERIOD != 0) step();
  endtask

  task automatic skip_periods(input int n);
    repeat (n * PERIOD) step();
  endtask

  task automatic wr(input int ch, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    wr_ch    = 2'(ch);
    wr_rgb   = {r, g, b};
    wr_valid = 1'b1;
    check("wr_ready_at_write", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic chk_ch(input string tag, input int ch, input int er, input int eg, input int eb);
    check($sformatf("%s_ch%0d_red", tag, ch), 32'(hr[ch]), 32'(er));
    check($sformatf("%s_ch%0d_grn", tag, ch), 32'(hg[ch]), 32'(eg));
    check($sformatf("%s_ch%0d_blu", tag, ch), 32'(hb[ch]), 32'(eb));
  endtask

  initial begin
    mode     = 2'd1;
    wr_valid = 1'b0;
    wr_ch    = 2'd0;
    wr_rgb   = '0;
    clear();

    // Reset held for 10 clks
    #1 rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_red", 32'(red), 32'd0);
    check("rst_grn", 32'(grn), 32'd0);
    check("rst_blu", 32'(blu), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(wr_ready), 32'd0);
    step();
    check("ready_after_release", 32'(wr_ready), 32'd1);
    check("red_after_release", 32'(red), 32'd0);

    // STATIC: ch0 {8,0,15}, visible from the next boundary
    wr(0, 4'd8, 4'd0, 4'd15);
    goto_boundary();
    measure();
    chk_ch("static", 0, 8, 0, 15);
    chk_ch("static", 1, 0, 0, 0);
    chk_ch("static", 2, 0, 0, 0);

    // Two writes to ch1 in one period (last wins) plus out-of-range channel 3
    clear();
    wr(1, 4'd4, 4'd4, 4'd4);
    wr(1, 4'd12, 4'd12, 4'd12);
    wr(3, 4'd15, 4'd15, 4'd15);
    repeat (PERIOD - 3) step();
    chk_ch("pending", 0, 8, 0, 15);
    chk_ch("pending", 1, 0, 0, 0);
    chk_ch("pending", 2, 0, 0, 0);
    measure();
    chk_ch("lastwins", 0, 8, 0, 15);
    chk_ch("lastwins", 1, 12, 12, 12);
    chk_ch("discard", 2, 0, 0, 0);

    // Write accepted exactly on the wrap tick: one more full old period
    clear();
    repeat (PERIOD - 1) step();
    wr(0, 4'd3, 4'd3, 4'd3);
    chk_ch("wrapwr_cur", 0, 8, 0, 15);
    measure();
    chk_ch("wrapwr_old", 0, 8, 0, 15);
    measure();
    chk_ch("wrapwr_new", 0, 3, 3, 3);
    chk_ch("wrapwr_new", 1, 12, 12, 12);

    // CYCLE: mode change takes effect at the next boundary
    mode = 2'd3;
    measure();
    chk_ch("cyc_pre", 0, 3, 3, 3);
    measure();
    chk_ch("cyc_p0", 0, 15, 0, 0);
    chk_ch("cyc_p0", 2, 15, 0, 0);
    skip_periods(15);
    measure();
    chk_ch("cyc_p16", 0, 0, 15, 0);
    chk_ch("cyc_p16", 1, 0, 15, 0);
    skip_periods(23);
    measure();
    chk_ch("cyc_p40", 0, 8, 0, 7);
    skip_periods(6);
    measure();
    chk_ch("cyc_p47", 0, 15, 0, 0);
    measure();
    chk_ch("cyc_wrap_p0", 0, 15, 0, 0);
    measure();
    chk_ch("cyc_p1", 1, 14, 1, 0);

    // OFF mid-period: pins drop on the next clk (p=2 gives red duty 13)
    repeat (3) step();
    check("pre_off_red", 32'(red), 32'd7);
    mode = 2'd0;
    step();
    check("off_red", 32'(red), 32'd0);
    check("off_grn", 32'(grn), 32'd0);
    check("off_blu", 32'(blu), 32'd0);
    goto_boundary();
    measure();
    chk_ch("off_period", 0, 0, 0, 0);

    // BREATHE with colour {15,15,15} on ch0
    mode = 2'd2;
    wr(0, 4'd15, 4'd15, 4'd15);
    goto_boundary();
`ifdef RGB_PWM_DRV_BREATHE_EN
    measure();
    chk_ch("br_b0", 0, 0, 0, 0);
    measure();
    chk_ch("br_b1", 0, 0, 0, 0);
    measure();
    chk_ch("br_b2", 0, 1, 1, 1);
    skip_periods(12);
    measure();
    chk_ch("br_b15", 0, 14, 14, 14);
    measure();
    chk_ch("br_b15_hold", 0, 14, 14, 14);
    measure();
    chk_ch("br_b14", 0, 13, 13, 13);
`else
    measure();
    chk_ch("br_static0", 0, 15, 15, 15);
    measure();
    chk_ch("br_static1", 0, 15, 15, 15);
    skip_periods(13);
    measure();
    chk_ch("br_static15", 0, 15, 15, 15);
    measure();
    chk_ch("br_static16", 0, 15, 15, 15);
`endif

    // Asynchronous reset mid-period clears the pins without a clk edge
    step();
    step();
    check("pre_rst_red0", 32'(red[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_red", 32'(red), 32'd0);
    check("async_rst_grn", 32'(grn), 32'd0);
    check("async_rst_blu", 32'(blu), 32'd0);
    check("async_rst_ready", 32'(wr_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
